// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used as the serial adder's datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through one full-adder cell.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One spare counter bit so a power-of-two WIDTH never wraps before the compare.
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             last;

    full_adder u_cell (
        .a   (opa[0]),
        .b   (opb[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b at load and seed the carry with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub | cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            res   <= WIDTH'({fa_s, res} >> 1);
            carry <= fa_co;
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            cnt   <= cnt + CW'(1);
        end
    end

    // After the last RUN edge the carry flop holds the carry out of the MSB.
    assign sum  = res;
    assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_v [2];
    logic       sub_v   [2];
    logic       cin_v   [2];
    logic [7:0] a_v     [2];
    logic [7:0] b_v     [2];

    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_v[1][0:0]), .b(b_v[1][0:0]), .cin(cin_v[1]),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    // Plain arithmetic: {cout,sum} = a + b + cin, or a + (2^w-1-b) + 1 for subtraction.
    function automatic logic [8:0] calc(input int w, input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic s);
        int mask;
        int bb;
        mask = (1 << w) - 1;
        bb   = s ? (mask - (int'(b) & mask)) : (int'(b) & mask);
        return 9'((int'(a) & mask) + bb + (s ? 1 : int'(c)));
    endfunction

    // Model: edges elapsed since the accepting edge (-1 when idle).
    int         since   [2];
    logic [8:0] expr    [2];
    logic [7:0] m_sum   [2];
    logic       m_cout  [2];
    logic       m_valid [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                since[i]   <= -1;
                m_sum[i]   <= 8'h00;
                m_cout[i]  <= 1'b0;
                m_valid[i] <= 1'b1;
            end else if (since[i] < 0) begin
                if (start_v[i]) begin
                    since[i]   <= 0;
                    expr[i]    <= calc(wid(i), a_v[i], b_v[i], cin_v[i], sub_v[i]);
                    m_valid[i] <= 1'b0;
                end
            end else if (since[i] == wid(i) - 1) begin
                since[i]   <= wid(i);
                m_sum[i]   <= expr[i][7:0] & 8'((1 << wid(i)) - 1);
                m_cout[i]  <= expr[i][wid(i)];
                m_valid[i] <= 1'b1;
            end else if (since[i] == wid(i)) begin
                since[i] <= -1;
            end else begin
                since[i] <= since[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic       b_a, d_a, c_a;
                logic [7:0] s_a;
                b_a = (i == 0) ? busy8 : busy1;
                d_a = (i == 0) ? done8 : done1;
                c_a = (i == 0) ? cout8 : cout1;
                s_a = (i == 0) ? sum8 : {7'b0, sum1};
                chk($sformatf("busy_w%0d", wid(i)), 64'(b_a), 64'(since[i] >= 0));
                chk($sformatf("done_w%0d", wid(i)), 64'(d_a), 64'(since[i] == wid(i)));
                if (m_valid[i]) begin
                    chk($sformatf("sum_w%0d", wid(i)), 64'(s_a), 64'(m_sum[i]));
                    chk($sformatf("cout_w%0d", wid(i)), 64'(c_a), 64'(m_cout[i]));
                end
            end
        end
    end

    task automatic op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic s, output int lat, output logic [7:0] s_o, output logic c_o);
        bit seen;
        @(negedge clk);
        a_v[i] = a; b_v[i] = b; cin_v[i] = c; sub_v[i] = s; start_v[i] = 1'b1;
        @(posedge clk);
        #1 start_v[i] = 1'b0;
        lat = 0; seen = 1'b0; s_o = 8'h00; c_o = 1'b0;
        while (!seen && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((i == 0) ? done8 : done1) begin
                seen = 1'b1;
                s_o  = (i == 0) ? sum8 : {7'b0, sum1};
                c_o  = (i == 0) ? cout8 : cout1;
            end else begin
                a_v[i] = 8'($urandom); b_v[i] = 8'($urandom);
                cin_v[i] = 1'($urandom); sub_v[i] = 1'($urandom);
            end
        end
        if (!seen) chk($sformatf("timeout_w%0d", wid(i)), 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         cnt;
        logic [7:0] s;
        logic       c;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; sub_v[i] = 1'b0; cin_v[i] = 1'b0;
            a_v[i] = 8'h00; b_v[i] = 8'h00;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy8", 64'(busy8), 64'(0));
        chk("rst_done8", 64'(done8), 64'(0));
        chk("rst_sum8", 64'(sum8), 64'(0));
        chk("rst_cout8", 64'(cout8), 64'(0));
        chk("rst_busy1", 64'(busy1), 64'(0));
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        op(0, 8'hFF, 8'h01, 1'b0, 1'b0, lat, s, c);
        chk("ff_plus_01_lat", 64'(lat), 64'(8));
        chk("ff_plus_01_sum", 64'(s), 64'h00);
        chk("ff_plus_01_cout", 64'(c), 64'(1));

        op(0, 8'h5A, 8'h25, 1'b1, 1'b0, lat, s, c);
        chk("5a_plus_25_sum", 64'(s), 64'h80);
        chk("5a_plus_25_cout", 64'(c), 64'(0));
        repeat (5) begin
            @(negedge clk);
            chk("hold_sum", 64'(sum8), 64'h80);
            chk("hold_cout", 64'(cout8), 64'(0));
        end

        op(0, 8'h10, 8'h01, 1'b0, 1'b1, lat, s, c);
        chk("10_minus_01_sum", 64'(s), 64'h0F);
        chk("10_minus_01_cout", 64'(c), 64'(1));
        op(0, 8'h01, 8'h02, 1'b1, 1'b1, lat, s, c);
        chk("01_minus_02_sum", 64'(s), 64'hFF);
        chk("01_minus_02_cout", 64'(c), 64'(0));

        // Second start with new operands while busy must be ignored.
        @(negedge clk);
        a_v[0] = 8'h12; b_v[0] = 8'h34; cin_v[0] = 1'b0; sub_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        a_v[0] = 8'hFF; b_v[0] = 8'hFF; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cnt = 0;
        while (!done8 && cnt < 50) begin @(negedge clk); cnt++; end
        chk("busy_start_sum", 64'(sum8), 64'h46);
        cnt = 0;
        repeat (12) begin @(negedge clk); if (done8) cnt++; end
        chk("busy_start_extra_done", 64'(cnt), 64'(0));

        // Reset mid-run.
        @(negedge clk);
        a_v[0] = 8'h40; b_v[0] = 8'h41; start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 64'(busy8), 64'(0));
        chk("midrun_rst_sum", 64'(sum8), 64'(0));
        chk("midrun_rst_done", 64'(done8), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (done8) cnt++; end
        chk("midrun_rst_no_done", 64'(cnt), 64'(0));
        op(0, 8'h03, 8'h04, 1'b0, 1'b0, lat, s, c);
        chk("after_rst_sum", 64'(s), 64'h07);
        chk("after_rst_lat", 64'(lat), 64'(8));

        // Start held high: back-to-back operations every 10 edges.
        @(negedge clk);
        a_v[0] = 8'h01; b_v[0] = 8'h01; start_v[0] = 1'b1;
        cnt = 0;
        repeat (35) begin @(negedge clk); if (done8) cnt++; end
        start_v[0] = 1'b0;
        chk("held_start_dones", 64'(cnt), 64'(3));
        cnt = 0;
        while (busy8 && cnt < 50) begin @(negedge clk); cnt++; end
        chk("held_start_drain", 64'(busy8), 64'(0));

        for (int k = 0; k < 8; k++) begin
            logic [7:0] ka, kb;
            logic       kc;
            ka = 8'((k >> 2) & 1); kb = 8'((k >> 1) & 1); kc = 1'(k & 1);
            op(1, ka, kb, kc, 1'b0, lat, s, c);
            chk($sformatf("w1_lat_%0d", k), 64'(lat), 64'(1));
            chk($sformatf("w1_sum_%0d", k), 64'({c, s[0]}), 64'(int'(ka) + int'(kb) + int'(kc)));
        end

        for (int n = 0; n < 30; n++) begin
            op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), lat, s, c);
            chk("rand_w8_lat", 64'(lat), 64'(8));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int n = 0; n < 10; n++) begin
            op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), lat, s, c);
            chk("rand_w1_lat", 64'(lat), 64'(1));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
